// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - operand and result valid/ready channels of the iterative divider
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU with flush
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic             ovf;
  logic             special_op;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] special;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  always_comb begin
    is_signed  = ~bus.op[0];
    a_neg      = is_signed & bus.a[WIDTH-1];
    b_neg      = is_signed & bus.b[WIDTH-1];
    a_abs      = a_neg ? -bus.a : bus.a;
    b_abs      = b_neg ? -bus.b : bus.b;
    ovf        = is_signed && (bus.a == MIN) && (bus.b == '1);
    special_op = !bus.op[2] || (bus.b == '0) || ovf;
    special    = '0;
    if (!bus.op[2])
      special = '0;
    else if (bus.b == '0)
      special = bus.op[1] ? bus.a : '1;
    else if (ovf)
      special = bus.op[1] ? '0 : MIN;

    // One extra bit on the partial remainder so divisors >= 2^(W-1) cannot overflow it
    rem_shift = {rem, dvd[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs};
    qbit      = ~rem_sub[WIDTH];
    rem_next  = qbit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {dvd[WIDTH-2:0], qbit};
    fin_q     = neg_q ? -quo_next : quo_next;
    fin_r     = neg_r ? -rem_next : rem_next;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      is_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd    <= a_abs;
            dvs    <= b_abs;
            rem    <= '0;
            is_rem <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (special_op) begin
              result_q    <= special;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              count <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          dvd   <= quo_next;
          count <= count - 1'b1;
          if (count == '0) begin
            result_q    <= is_rem ? fin_r : fin_q;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
